// File: rtl/xor_pkg.sv
// Shared definitions for the 32-bit XOR scrambling stage.
// The transmit-side scrambler and the receive-side descrambler both import
// this package, so the two ends agree on width, polynomial, default seed
// and state encoding.
package xor_pkg;

  // Data and keystream width. Only 32 is supported.
  localparam int WIDTH = 32;

  // Default Galois feedback polynomial (CRC-32 taps).
  localparam logic [WIDTH-1:0] XOR_DEF_POLY = 32'h04C11DB7;

  // Seed substituted when a zero seed is loaded. A zero key would lock the
  // LFSR at zero and turn descrambling into a pass-through.
  localparam logic [WIDTH-1:0] XOR_DEF_SEED = 32'hFFFF_FFFF;

  // Stream state encodings.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage : xor_pkg

// File: rtl/lfsr32_step.sv
// One step of the 32-bit Galois LFSR keystream: shift left by one and fold
// the bit shifted out back in through the feedback polynomial. Purely
// combinational so the scrambler and descrambler can share it bit for bit.
module lfsr32_step
  import xor_pkg::*;
#(
  parameter logic [WIDTH-1:0] POLY = XOR_DEF_POLY
) (
  input  logic [WIDTH-1:0] i_key,
  output logic [WIDTH-1:0] o_next
);

  assign o_next = {i_key[WIDTH-2:0], 1'b0} ^ (i_key[WIDTH-1] ? POLY : '0);

endmodule : lfsr32_step

// File: rtl/xor_stream_descrambler.sv
// Receive-side XOR descrambler. Each accepted scrambled word is XORed with
// the current LFSR key and presented through a single registered output
// stage; the key then advances one step. A seed_load strobe restarts the
// keystream, clears the word counter and drops any pending output word.
module xor_stream_descrambler
  import xor_pkg::*;
#(
  parameter logic [WIDTH-1:0] POLY     = XOR_DEF_POLY,
  parameter logic [WIDTH-1:0] DEF_SEED = XOR_DEF_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      word_count,
  output logic             running
);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_key;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [15:0]      r_word_count;

  logic [WIDTH-1:0] w_key_next;
  logic [WIDTH-1:0] w_seed_key;
  logic             w_running;
  logic             w_in_ready;
  logic             w_accept;

  lfsr32_step #(
    .POLY (POLY)
  ) u_lfsr_step (
    .i_key  (r_key),
    .o_next (w_key_next)
  );

  // A zero seed would freeze the keystream, so it is replaced by DEF_SEED.
  assign w_seed_key = (seed == '0) ? DEF_SEED : seed;

  // The output register can take a new word when it is empty or is being
  // drained this cycle; seed_load blocks acceptance so the sender holds its
  // word until the new keystream is in place.
  assign w_running  = (r_state == ST_RUN);
  assign w_in_ready = w_running && !seed_load && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  // State, keystream, output stage and word counter.
  // NOTE: non-blocking assignments keep every register reading the values
  // from before the edge, so key, counter and output update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_key        <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_word_count <= '0;
    end else if (seed_load) begin
      r_state      <= ST_RUN;
      r_key        <= w_seed_key;
      r_out_valid  <= 1'b0;
      r_word_count <= '0;
    end else if (w_accept) begin
      r_key        <= w_key_next;
      r_out_data   <= in_data ^ r_key;
      r_out_valid  <= 1'b1;
      r_word_count <= r_word_count + 16'd1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign word_count = r_word_count;
  assign running    = w_running;

endmodule : xor_stream_descrambler

// File: doc/xor_stream_descrambler.md
# xor_stream_descrambler

- Receive-side counterpart of the 32-bit XOR scrambling stage.
- Recovers plaintext words by XORing each incoming scrambled word with a keystream from a 32-bit Galois LFSR. The transmit side generates the same keystream from the same seed.
- Sits between the link receive path and the consumer.
- Valid/ready handshakes on both sides, one registered output stage, and a word counter for frame bookkeeping.

## Interface
Parameters:
- WIDTH, 32, data and keystream width. Only 32 is supported.
- POLY, 32'h04C11DB7, Galois feedback polynomial.
- DEF_SEED, 32'hFFFFFFFF, seed substituted when a zero seed is loaded.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- seed_load  input  1  one-cycle strobe; load seed and restart the stream.
- seed  input  32  keystream seed, sampled when seed_load=1.
- in_valid  input  1  scrambled word available.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  32  scrambled word.
- out_valid  output  1  out_data holds a descrambled word.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  32  descrambled word.
- word_count  output  16  words accepted since the last seed_load.
- running  output  1  high in RUN state.

## Operation
- Two states:
  - IDLE (after reset, no valid seed yet).
  - RUN.
- IDLE: in_ready=0. seed_load moves the block to RUN.
- seed_load handling, in any state:
  - key <= (seed==0 ? DEF_SEED : seed).
  - word_count <= 0.
  - out_valid <= 0; any pending output word is discarded.
  - state <= RUN.
- in_ready = running && !seed_load && (!out_valid || out_ready).
- Input accept occurs when in_valid && in_ready:
  - out_data <= in_data ^ key.
  - out_valid <= 1.
  - key <= next(key).
  - word_count <= word_count + 1, wrapping 0xFFFF to 0x0000.
- Keystream step: next(k) = {k[30:0],1'b0} ^ (k[31] ? POLY : 0).
  - The key is never zero, because the seed is never zero and the step is invertible.
- Output handshake: out_valid && out_ready with no new accept gives out_valid <= 0. out_data holds its last value.
- out_data and out_valid stay stable while out_valid && !out_ready.
- Same-cycle output-complete and input-accept: out_valid stays 1 and out_data takes the new word. This gives full throughput of one word per cycle.
- seed_load has priority over a same-cycle in_valid. That input word is not accepted, and the sender must hold it.

## Timing
- Reset values (rst_n=0 at a clock edge):
  - state=IDLE, key=0, word_count=0.
  - out_valid=0, out_data=0.
  - in_ready=0, running=0.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N. That is one cycle.
- seed_load at edge N: running=1 after N, and the first word can be accepted at edge N+1.
- in_ready is combinational from out_ready, seed_load and state. No other input-to-output combinational paths exist.
- Reset asserted mid-stream: the pending output and keystream position are lost, and a new seed_load is required.

## Structure
- Shared package/header xor_pkg holds:
  - the WIDTH constant;
  - the default POLY and DEF_SEED;
  - the state encodings IDLE=1'b0 and RUN=1'b1.
- The transmit-side scrambler uses the same package.
- One sub-module: lfsr32_step, a purely combinational next-key function parameterized by POLY.
  - The same sub-module is reused on the scrambler side so both ends stay bit-identical.
- The top level holds the state register, key register, output register and counter.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles, then in_valid=1 with no seed_load.
  - Required: in_ready=0, out_valid=0, out_data=0 and word_count=0 throughout.
- Seed=1, then send 0x00000001, 0x00000002, 0x00000004 back-to-back with out_ready=1.
  - Required: out_data = 0, 0, 0 on consecutive cycles, and word_count=3.
- Keystream wrap: seed=1, then 33 words of 0x00000000.
  - Required: word 32 is 0x80000000 and word 33 is 0x04C11DB7.
- Zero seed: seed_load with seed=0, then input 0xFFFFFFFF.
  - Required: output 0x00000000, because DEF_SEED is used.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1.
  - Required: out_data held, in_ready=0, and no word lost or duplicated after out_ready=1.
  - Round trip: a random stream through the matching scrambler with the same seed reproduces its input exactly.
- seed_load during backpressure with out_valid=1 and in_valid=1.
  - Required: out_valid=0 next cycle, word_count=0, the input word is not accepted, and that word is then descrambled with the new seed's first key.
